// File: rtl/spi_pkg.sv
// spi_pkg: shared word width default, load delay and state encoding for the SPI slave front end.
package spi_pkg;
   localparam int SPI_DATA_W     = 8;
   localparam int SPI_LOAD_DELAY = 3;
   typedef enum logic {IDLE, ACTIVE} spi_state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: pin synchroniser with rise/fall pulses.
// SPI_SLAVE_SERDES_GLITCH_FILTER_EN adds a 3-sample majority filter (+2 cycles latency).
module sync_edge_detect #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic lvl,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sr;
   logic prev;
   always_ff @(posedge clk)
      if (rst) sr <= {STAGES{INIT}};
      else sr <= {sr[STAGES-2:0], d};
`ifdef SPI_SLAVE_SERDES_GLITCH_FILTER_EN
   logic [1:0] hist;
   logic filt;
   logic s;
   assign s = sr[STAGES-1];
   always_ff @(posedge clk)
      if (rst) begin
         hist <= {2{INIT}};
         filt <= INIT;
      end else begin
         hist <= {hist[0], s};
         filt <= (s & hist[0]) | (s & hist[1]) | (hist[0] & hist[1]);
      end
   assign lvl = filt;
`else
   assign lvl = sr[STAGES-1];
`endif
   always_ff @(posedge clk)
      if (rst) prev <= INIT;
      else prev <= lvl;
   assign rise = lvl & ~prev;
   assign fall = ~lvl & prev;
endmodule

// File: rtl/spi_slave_serdes.sv
// spi_slave_serdes: oversampled SPI mode-0 slave producing start/next/stop byte events and serialising to_spi on miso.
// SPI_SLAVE_SERDES_GLITCH_FILTER_EN enables majority filtering of sclk and cs_n.
module spi_slave_serdes
   import spi_pkg::*;
#(
   parameter int DATA_BUS_WIDTH = SPI_DATA_W,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sclk,
   input  logic                      cs_n,
   input  logic                      mosi,
   output logic                      miso,
   output logic                      miso_oe,
   output logic                      spi_start,
   output logic                      spi_next,
   output logic                      spi_stop,
   output logic [DATA_BUS_WIDTH-1:0] from_spi,
   input  logic [DATA_BUS_WIDTH-1:0] to_spi
);
   localparam int W  = DATA_BUS_WIDTH;
   localparam int BW = $clog2(W);
   localparam logic [BW-1:0] LAST = BW'(W - 1);
   localparam logic [1:0] LOAD = 2'(SPI_LOAD_DELAY);
`ifdef SPI_SLAVE_SERDES_GLITCH_FILTER_EN
   localparam int MOSI_STAGES = SYNC_STAGES + 2;
`else
   localparam int MOSI_STAGES = SYNC_STAGES;
`endif
   spi_state_t state;
   logic [BW-1:0] bit_cnt;
   logic [W-1:0] rx_sr, tx_sr;
   logic [1:0] ld_cnt;
   logic done;
   logic [MOSI_STAGES-1:0] mosi_sr;
   logic mosi_s;
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   sync_edge_detect #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
      .clk(clk), .rst(rst), .d(sclk), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
   );
   sync_edge_detect #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
      .clk(clk), .rst(rst), .d(cs_n), .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
   );
   // mosi delay matches the sclk path so each sample is taken with its own edge
   always_ff @(posedge clk)
      if (rst) mosi_sr <= '0;
      else mosi_sr <= {mosi_sr[MOSI_STAGES-2:0], mosi};
   assign mosi_s = mosi_sr[MOSI_STAGES-1];
   always_ff @(posedge clk)
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         ld_cnt    <= '0;
         done      <= 1'b0;
         spi_start <= 1'b0;
         spi_next  <= 1'b0;
         spi_stop  <= 1'b0;
         from_spi  <= '0;
      end else begin
         spi_start <= 1'b0;
         spi_stop  <= 1'b0;
         spi_next  <= done;
         done      <= 1'b0;
         if (done) begin
            from_spi <= rx_sr;
            ld_cnt   <= LOAD;
         end else if (ld_cnt != 2'd0) ld_cnt <= ld_cnt - 2'd1;
         if (state == IDLE) begin
            if (cs_fall) begin
               state     <= ACTIVE;
               spi_start <= 1'b1;
               bit_cnt   <= '0;
               rx_sr     <= '0;
               tx_sr     <= '0;
               ld_cnt    <= '0;
            end
         end else if (cs_rise) begin
            state    <= IDLE;
            spi_stop <= 1'b1;
            bit_cnt  <= '0;
            ld_cnt   <= '0;
         end else begin
            if (sclk_rise) begin
               rx_sr   <= {rx_sr[W-2:0], mosi_s};
               bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
               done    <= (bit_cnt == LAST);
            end
            if (ld_cnt == 2'd1) tx_sr <= to_spi;
            else if (sclk_fall && bit_cnt != '0) tx_sr <= {tx_sr[W-2:0], 1'b0};
         end
      end
   assign miso    = tx_sr[W-1];
   assign miso_oe = (state == ACTIVE);
endmodule

// File: tb/tb_spi_slave_serdes.sv
// tb_spi_slave_serdes: directed bench with an rx scoreboard and a to_spi turnaround driver.
module tb_spi_slave_serdes;
   logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
   logic miso, miso_oe, spi_start, spi_next, spi_stop;
   logic [7:0] from_spi, to_spi;
   int total = 0, bad = 0;
   int n_start = 0, n_next = 0, n_stop = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
`ifdef SPI_SLAVE_SERDES_GLITCH_FILTER_EN
   localparam int HMIN = 6;
`else
   localparam int HMIN = 4;
`endif
   localparam int H = 6;

   spi_slave_serdes dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .spi_start(spi_start), .spi_next(spi_next),
      .spi_stop(spi_stop), .from_spi(from_spi), .to_spi(to_spi)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (spi_start) n_start++;
      if (spi_stop) n_stop++;
      if (spi_next) begin
         n_next++;
         if (rx_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL rx_unexpected observed=%0h expected=none", from_spi);
         end else chk("rx_word", from_spi, rx_q.pop_front());
      end
   end

   // Bridge model: read data appears exactly 2 cycles after spi_next, junk otherwise
   initial begin
      to_spi = 8'hEE;
      forever begin
         @(negedge clk);
         if (spi_next) begin
            @(posedge clk);
            @(posedge clk);
            #1 to_spi = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
            @(posedge clk);
            #1 to_spi = 8'hEE;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic begin_xfer(input int h);
      cs_n = 1'b0;
      tick(h);
   endtask

   task automatic end_xfer(input int h);
      tick(h);
      cs_n = 1'b1;
      tick(10);
   endtask

   task automatic word(input logic [7:0] d, input int h, output logic [7:0] m);
      rx_q.push_back(d);
      for (int i = 7; i >= 0; i--) begin
         mosi = d[i];
         tick(h);
         m[i] = miso;
         sclk = 1'b1;
         tick(h);
         sclk = 1'b0;
      end
   endtask

   task automatic partial(input logic [7:0] d, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = d[i];
         tick(H);
         sclk = 1'b1;
         tick(H);
         sclk = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] m0, m1, m2, m3;
      int s0, n0, p0;
      tick(4);
      chk("rst_from_spi", from_spi, 8'h00);
      chk("rst_miso", miso, 1'b0);
      chk("rst_miso_oe", miso_oe, 1'b0);
      chk("rst_pulses", {spi_start, spi_next, spi_stop}, 3'b000);
      rst = 1'b0;
      tick(6);

      s0 = n_start; n0 = n_next; p0 = n_stop;
      begin_xfer(H);
      chk("oe_active", miso_oe, 1'b1);
      word(8'hA5, H, m0);
      end_xfer(H);
      chk("basic_start", n_start - s0, 1);
      chk("basic_next", n_next - n0, 1);
      chk("basic_stop", n_stop - p0, 1);
      chk("basic_miso", m0, 8'h00);
      chk("oe_idle", miso_oe, 1'b0);

      tx_q.push_back(8'h3C);
      begin_xfer(H);
      word(8'h11, H, m0);
      word(8'h5A, H, m1);
      end_xfer(H);
      chk("turn_first", m0, 8'h00);
      chk("turn_second", m1, 8'h3C);

      n0 = n_next; p0 = n_stop;
      begin_xfer(H);
      partial(8'hFF, 5);
      end_xfer(H);
      chk("abort_next", n_next - n0, 0);
      chk("abort_stop", n_stop - p0, 1);
      chk("abort_hold", from_spi, 8'h5A);
      begin_xfer(H);
      word(8'h81, H, m0);
      end_xfer(H);
      chk("after_abort_miso", m0, 8'h00);

      n0 = n_next;
      tx_q.push_back(8'h11);
      tx_q.push_back(8'h22);
      tx_q.push_back(8'h33);
      begin_xfer(2);
      word(8'h01, HMIN, m0);
      word(8'h02, HMIN, m1);
      word(8'h03, HMIN, m2);
      word(8'h04, HMIN, m3);
      end_xfer(HMIN);
      chk("b2b_next", n_next - n0, 4);
      chk("b2b_miso0", m0, 8'h00);
      chk("b2b_miso1", m1, 8'h11);
      chk("b2b_miso2", m2, 8'h22);
      chk("b2b_miso3", m3, 8'h33);

      s0 = n_start; n0 = n_next; p0 = n_stop;
      for (int i = 0; i < 6; i++) begin
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
         tick(4);
      end
      tick(6);
      chk("noise_pulses", {n_start - s0, n_next - n0, n_stop - p0}, 96'h0);
      chk("noise_oe", miso_oe, 1'b0);

      begin_xfer(H);
      partial(8'hF0, 3);
      rst = 1'b1;
      tick(2);
      chk("midrst_from_spi", from_spi, 8'h00);
      chk("midrst_oe", miso_oe, 1'b0);
      chk("midrst_miso", miso, 1'b0);
      chk("midrst_pulses", {spi_start, spi_next, spi_stop}, 3'b000);
      cs_n = 1'b1;
      sclk = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(8);
      begin_xfer(H);
      word(8'hC3, H, m0);
      end_xfer(H);
      chk("postrst_miso", m0, 8'h00);

      // Extra 1-cycle sclk pulse before bit 3: filtered away, or counted as a spurious rise
      n0 = n_next;
`ifdef SPI_SLAVE_SERDES_GLITCH_FILTER_EN
      rx_q.push_back(8'hA5);
`else
      rx_q.push_back(8'hA2);
`endif
      begin_xfer(H);
      for (int i = 7; i >= 0; i--) begin
         mosi = m0[0] ^ m0[0] ^ ((8'hA5 >> i) & 8'h01) != 0;
         if (i == 3) begin
            tick(2);
            sclk = 1'b1;
            tick(1);
            sclk = 1'b0;
            tick(H - 3);
         end else tick(H);
         sclk = 1'b1;
         tick(H);
         sclk = 1'b0;
      end
      end_xfer(H);
      chk("glitch_next", n_next - n0, 1);
      chk("queue_empty", rx_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
